// File: rtl/debounce_en.sv
// rtl/debounce_en.sv - input synchronizer and debouncer with registered level, edge pulses and enable
// Optional abort counter on glitch_cnt is built only when DEBOUNCE_GLITCH_CNT_EN is defined.
module debounce_en #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       tick_en,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       en_out,
    output logic [7:0] glitch_cnt
);

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   q_n, rise_n, fall_n;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync   <= '0;
            state  <= STABLE_LO;
            cnt    <= '0;
            q      <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            en_out <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], din};
            state  <= state_n;
            cnt    <= cnt_n;
            q      <= q_n;
            rise   <= rise_n;
            fall   <= fall_n;
            en_out <= rise_n | fall_n;
        end
    end

    // A reverting s always wins over a terminal tick in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        q_n     = q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_n = STABLE_LO;
                end else if (tick_en) begin
                    if (cnt == LAST) begin
                        state_n = STABLE_HI;
                        q_n     = 1'b1;
                        rise_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_n = STABLE_HI;
                end else if (tick_en) begin
                    if (cnt == LAST) begin
                        state_n = STABLE_LO;
                        q_n     = 1'b0;
                        fall_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = STABLE_LO;
        endcase
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] gcnt;

    assign abort = ((state == WAIT_HI) && !s) || ((state == WAIT_LO) && s);

    // Saturating so a noisy line cannot wrap back to a small value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gcnt <= 8'd0;
        end else if (abort && (gcnt != 8'hFF)) begin
            gcnt <= gcnt + 8'd1;
        end
    end

    assign glitch_cnt = gcnt;
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debounce_en.sv
// tb/tb_debounce_en.sv - directed self-checking bench for debounce_en at default parameters
module tb_debounce_en;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       tick_en;
    logic       q;
    logic       rise;
    logic       fall;
    logic       en_out;
    logic [7:0] glitch_cnt;

    int compared   = 0;
    int mismatched = 0;
    logic q_seen;
    logic pulse_seen;

    debounce_en dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .tick_en    (tick_en),
        .q          (q),
        .rise       (rise),
        .fall       (fall),
        .en_out     (en_out),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gexp(input int n);
        return GC ? 8'(n) : 8'd0;
    endfunction

    initial begin
        rst = 1'b0; din = 1'b1; tick_en = 1'b1;
        step(3);
        check("reset_q", q, 0);
        check("reset_rise", rise, 0);
        check("reset_fall", fall, 0);
        check("reset_en", en_out, 0);
        check("reset_glitch", glitch_cnt, 0);

        // Rise: 7 edges after release with din held high
        rst = 1'b1;
        step(6);
        check("rise_q_edge6", q, 0);
        step(1);
        check("rise_q_edge7", q, 1);
        check("rise_pulse", rise, 1);
        check("rise_en", en_out, 1);
        check("rise_nofall", fall, 0);
        step(1);
        check("rise_pulse_end", rise, 0);
        check("rise_en_end", en_out, 0);
        check("rise_q_hold", q, 1);

        // Fall: 7 edges after din drops
        din = 1'b0;
        step(6);
        check("fall_q_edge6", q, 1);
        step(1);
        check("fall_q_edge7", q, 0);
        check("fall_pulse", fall, 1);
        check("fall_en", en_out, 1);
        check("fall_norise", rise, 0);
        step(1);
        check("fall_pulse_end", fall, 0);
        check("fall_en_end", en_out, 0);
        step(5);
        check("fall_q_hold", q, 0);

        // Short pulse: 3 cycles high then low aborts
        din = 1'b1;
        step(3);
        din = 1'b0;
        q_seen = 1'b0; pulse_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1);
            q_seen = q_seen | q;
            pulse_seen = pulse_seen | rise | fall | en_out;
        end
        check("short_q", q_seen, 0);
        check("short_pulses", pulse_seen, 0);
        check("short_glitch", glitch_cnt, gexp(1));

        // s reverts on the same edge as the terminal tick
        din = 1'b1;
        step(4);
        din = 1'b0;
        step(3);
        check("simul_q", q, 0);
        check("simul_rise", rise, 0);
        step(5);
        check("simul_q_after", q, 0);
        check("simul_glitch", glitch_cnt, gexp(2));

        // Slow tick: one strobe every 10th cycle
        tick_en = 1'b0; din = 1'b1;
        step(3);
        for (int t = 1; t <= 4; t++) begin
            q_seen = 1'b0;
            for (int i = 0; i < 9; i++) begin
                step(1);
                q_seen = q_seen | q;
            end
            check($sformatf("tick%0d_between", t), q_seen, 0);
            tick_en = 1'b1;
            step(1);
            tick_en = 1'b0;
            check($sformatf("tick%0d_q", t), q, (t == 4) ? 8'd1 : 8'd0);
        end
        check("tick_rise", rise, 1);
        step(5);
        check("tick_q_hold", q, 1);
        check("tick_rise_end", rise, 0);

        // Back to 0, then reset in WAIT_HI at cnt=2
        tick_en = 1'b1; din = 1'b0;
        step(7);
        check("ret_q", q, 0);
        step(1);
        din = 1'b1;
        step(5);
        rst = 1'b0;
        step(1);
        check("midrst_q", q, 0);
        check("midrst_rise", rise, 0);
        check("midrst_fall", fall, 0);
        check("midrst_en", en_out, 0);
        check("midrst_glitch", glitch_cnt, 0);
        rst = 1'b1;
        step(6);
        check("midrst_q_edge6", q, 0);
        step(1);
        check("midrst_q_edge7", q, 1);
        check("midrst_rise_edge7", rise, 1);

        // Glitch saturation: 300 two-cycle pulses from q=0
        din = 1'b0;
        step(8);
        check("sat_start_q", q, 0);
        q_seen = 1'b0;
        for (int g = 0; g < 300; g++) begin
            din = 1'b1;
            step(2);
            din = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step(1);
                q_seen = q_seen | q;
            end
        end
        check("sat_q", q_seen, 0);
        check("sat_glitch", glitch_cnt, GC ? 8'd255 : 8'd0);
        din = 1'b1;
        step(2);
        din = 1'b0;
        step(6);
        check("sat_glitch_hold", glitch_cnt, GC ? 8'd255 : 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
